// File: rtl/rf_writeback_arbiter.sv
// Write-back arbiter: sole driver of the register-file write port. Merges ALU results with
// buffered load results and keeps the pending-load scoreboard used by decode for hazard stalls.
module rf_writeback_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_issue,
    input  logic [4:0]      ld_issue_rd,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_busy,
    output logic            wb_stall,
    output logic            reg_wr,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {SEL_NONE, SEL_ALU, SEL_FIFO, SEL_LD} sel_e;

    sel_e            sel;
    logic            ld_accept, fifo_empty, push, pop;
    logic [4:0]      fifo_rd_q   [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            wb_stall_q, wb_stall_d;
    logic            reg_wr_q, reg_wr_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [31:0]     busy_q, busy_d;

    // A pop in the same cycle deliberately does not free a slot: ready depends on state only.
    assign ld_ready   = (count_q != CW'(DEPTH));
    assign ld_accept  = ld_valid && ld_ready;
    assign fifo_empty = (count_q == '0);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sel        = SEL_NONE;
        reg_wr_d   = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        starve_d   = starve_q;
        busy_d     = busy_q;

        if (alu_valid && alu_rd != 5'd0)      sel = SEL_ALU;
        else if (!fifo_empty)                 sel = SEL_FIFO;
        else if (ld_accept && ld_rd != 5'd0)  sel = SEL_LD;

        push = ld_accept && (ld_rd != 5'd0) && (sel != SEL_LD);
        pop  = (sel == SEL_FIFO);

        case (sel)
            SEL_ALU:  begin reg_wr_d = 1'b1; waddr_d = alu_rd; wdata_d = alu_data; end
            SEL_FIFO: begin
                reg_wr_d = 1'b1;
                waddr_d  = fifo_rd_q[rd_ptr_q];
                wdata_d  = fifo_data_q[rd_ptr_q];
            end
            SEL_LD:   begin reg_wr_d = 1'b1; waddr_d = ld_rd; wdata_d = ld_data; end
            default:  ;
        endcase

        if (push) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
        if (pop)  rd_ptr_d = AW'(rd_ptr_q + 1'b1);
        case ({push, pop})
            2'b10:   count_d = CW'(count_q + 1'b1);
            2'b01:   count_d = CW'(count_q - 1'b1);
            default: ;
        endcase

        // Only a blocked, non-empty FIFO ages the head; saturate so a protocol slip cannot wrap.
        if (pop || fifo_empty)                               starve_d = '0;
        else if (sel == SEL_ALU && starve_q != SW'(STARVE_LIMIT)) starve_d = SW'(starve_q + 1'b1);
        wb_stall_d = (starve_d == SW'(STARVE_LIMIT));

        // Clear before set so an issue to the register being written keeps it pending.
        if (sel == SEL_FIFO || sel == SEL_LD) busy_d[waddr_d] = 1'b0;
        if (ld_issue && ld_issue_rd != 5'd0)  busy_d[ld_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            wb_stall_q <= 1'b0;
            reg_wr_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            wb_stall_q <= wb_stall_d;
            reg_wr_q   <= reg_wr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
        end
    end

    // NOTE: FIFO storage is not reset; the count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= ld_rd;
            fifo_data_q[wr_ptr_q] <= ld_data;
        end
    end

    assign rs1_busy = busy_q[rs1];
    assign rs2_busy = busy_q[rs2];
    assign rd_busy  = busy_q[rd];
    assign wb_stall = wb_stall_q;
    assign reg_wr   = reg_wr_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed scenarios plus random traffic, all checked against a
// queue-based model of the write-back rules.
module tb_rf_writeback_arbiter;

    localparam int XLEN = 32, DEPTH = 4, STARVE_LIMIT = 4;

    logic            clk = 1'b0, reset;
    logic            alu_valid, ld_issue, ld_valid, ld_ready;
    logic [4:0]      alu_rd, ld_issue_rd, ld_rd, rs1, rs2, rd;
    logic [XLEN-1:0] alu_data, ld_data, wdata;
    logic            rs1_busy, rs2_busy, rd_busy, wb_stall, reg_wr;
    logic [4:0]      waddr;

    int checks = 0, errors = 0;

    rf_writeback_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
        .wb_stall(wb_stall), .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            mq[$];
    bit   [31:0]     m_busy;
    int              m_starve;
    logic            m_reg_wr, m_stall;
    logic [4:0]      m_waddr;
    logic [XLEN-1:0] m_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy   = '0;
        m_starve = 0;
        m_reg_wr = 1'b0;
        m_stall  = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
    endtask

    task automatic check_regs();
        check("reg_wr", reg_wr, m_reg_wr);
        check("waddr", waddr, m_waddr);
        check("wdata", wdata, m_wdata);
        check("wb_stall", wb_stall, m_stall);
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_issue = 0; ld_issue_rd = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        rs1 = 0; rs2 = 0; rd = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One clock: check registered outputs, drive, check combinational outputs, advance the model.
    task automatic step(input logic av, input logic [4:0] ar, input logic [XLEN-1:0] ad,
                        input logic iv, input logic [4:0] ir,
                        input logic lv, input logic [4:0] lr, input logic [XLEN-1:0] ldd,
                        input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] q3);
        bit   acc, was_nonempty, clr;
        ent_t e;
        check_regs();
        if (m_stall) av = 1'b0;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_issue = iv; ld_issue_rd = ir;
        ld_valid = lv; ld_rd = lr; ld_data = ldd;
        rs1 = q1; rs2 = q2; rd = q3;
        #1;
        check("ld_ready", ld_ready, mq.size() < DEPTH);
        check("rs1_busy", rs1_busy, m_busy[q1]);
        check("rs2_busy", rs2_busy, m_busy[q2]);
        check("rd_busy", rd_busy, m_busy[q3]);

        acc          = lv && (mq.size() < DEPTH);
        was_nonempty = (mq.size() != 0);
        clr          = 1'b0;
        if (av && ar != 0) begin
            m_reg_wr = 1; m_waddr = ar; m_wdata = ad;
            if (acc && lr != 0) mq.push_back('{lr, ldd});
            if (was_nonempty) m_starve++;
        end else if (was_nonempty) begin
            e = mq.pop_front();
            m_reg_wr = 1; m_waddr = e.rd; m_wdata = e.data; clr = 1;
            if (acc && lr != 0) mq.push_back('{lr, ldd});
            m_starve = 0;
        end else if (acc && lr != 0) begin
            m_reg_wr = 1; m_waddr = lr; m_wdata = ldd; clr = 1;
        end else begin
            m_reg_wr = 0;
        end
        if (!was_nonempty) m_starve = 0;
        m_stall = (m_starve == STARVE_LIMIT);
        if (clr) m_busy[m_waddr] = 1'b0;
        if (iv && ir != 0) m_busy[ir] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state.
        check("rst_reg_wr", reg_wr, 1'b0);
        check("rst_waddr", waddr, 5'd0);
        check("rst_wdata", wdata, 32'd0);

        // ALU write appears one cycle later.
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t1_reg_wr", reg_wr, 1'b1);
        check("t1_waddr", waddr, 5'd5);
        check("t1_wdata", wdata, 32'hDEADBEEF);

        // x0 destinations never write or become busy.
        step(1, 0, 32'h1111, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t4_alu_x0", reg_wr, 1'b0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h2222, 0, 0, 0);
        check("t4_ld_x0", reg_wr, 1'b0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        rd = 0; #1;
        check("t4_busy_x0", rd_busy, 1'b0);

        // Pending load on x7, then its bypass write clears busy in the same cycle reg_wr rises.
        step(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
        rs1 = 7; #1;
        check("t2_busy_set", rs1_busy, 1'b1);
        step(0, 0, 0, 0, 0, 1, 7, 32'h1234, 7, 0, 0);
        check("t2_reg_wr", reg_wr, 1'b1);
        check("t2_waddr", waddr, 5'd7);
        check("t2_wdata", wdata, 32'h1234);
        check("t2_busy_clr", rs1_busy, 1'b0);

        // Set and clear of the same register in one cycle: set wins.
        step(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3, 1, 3, 32'h3333, 0, 0, 3);
        rd = 3; #1;
        check("t6_busy_keep", rd_busy, 1'b1);

        // FIFO fill under continuous ALU traffic, starvation stall, then in-order drain.
        for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 5'(i), 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++)
            step(1, 20, 32'(100 + i), 0, 0, 1, 5'(i), 32'(32'hA0 + i), 0, 0, 0);
        check("t3_full", ld_ready, 1'b0);
        step(1, 20, 32'd105, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t3_stall", wb_stall, 1'b1);
        step(1, 20, 32'd106, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t3_head_addr", waddr, 5'd1);
        check("t3_head_data", wdata, 32'hA1);
        check("t3_stall_drop", wb_stall, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            check("t3_drain_addr", waddr, 5'(i));
            check("t3_drain_data", wdata, 32'(32'hA0 + i));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with three buffered loads and x9 pending.
        step(0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0);
        step(1, 21, 32'd1, 1, 10, 1, 9, 32'h9, 0, 0, 0);
        step(1, 21, 32'd2, 1, 11, 1, 10, 32'hA, 0, 0, 0);
        step(1, 21, 32'd3, 0, 0, 1, 11, 32'hB, 0, 0, 0);
        do_reset();
        rd = 9; #1;
        check("t5_reg_wr", reg_wr, 1'b0);
        check("t5_busy9", rd_busy, 1'b0);
        check("t5_ld_ready", ld_ready, 1'b1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 9);
        check("t5_no_drain", reg_wr, 1'b0);

        // Random traffic that obeys the upstream protocol (no ALU write to a pending register).
        for (int n = 0; n < 600; n++) begin
            logic       av, iv, lv;
            logic [4:0] ar, ir, lr;
            if ($urandom_range(99) == 0) begin
                do_reset();
                continue;
            end
            av = ($urandom_range(99) < 55);
            ar = 5'($urandom_range(31));
            if (m_busy[ar]) av = 1'b0;
            iv = ($urandom_range(99) < 30);
            ir = 5'($urandom_range(31));
            lv = ($urandom_range(99) < 45);
            lr = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            step(av, ar, $urandom, iv, ir, lv, lr, $urandom,
                 5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)));
        end
        check_regs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
